// File: rtl/mux_stream_rr_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package mux_stream_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, never below 1 so that a 2-channel mux still has a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_stream_rr_rr_arbiter.sv
// Combinational rotate-priority arbiter: search starts just after ptr and wraps.
module rr_arbiter
    import mux_stream_rr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          gnt,
    output logic [clog2(N)-1:0]   gnt_idx,
    output logic                  gnt_valid
);

    localparam int SW = clog2(N);

    always_comb begin
        int idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream mux with a registered output stage and
// fixed-select or round-robin arbitration.
module mux_stream_rr
    import mux_stream_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*WIDTH-1:0]    in_data,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic                  mode,
    input  logic [clog2(N)-1:0]   sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(N)-1:0]   out_chan
);

    localparam int SW = clog2(N);

    logic [SW-1:0]    rr_ptr;
    logic [N-1:0]     rr_gnt;
    logic [SW-1:0]    rr_gnt_idx;
    logic             rr_gnt_valid;

    logic [N-1:0]     fixed_gnt;
    logic [SW-1:0]    fixed_idx;
    logic             fixed_valid;

    logic [N-1:0]     grant_onehot;
    logic [SW-1:0]    grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             take;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_gnt_idx),
        .gnt_valid (rr_gnt_valid)
    );

    // Out-of-range sel values match no channel, so they never grant.
    always_comb begin
        fixed_gnt   = '0;
        fixed_idx   = '0;
        fixed_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i) && in_valid[i]) begin
                fixed_gnt[i] = 1'b1;
                fixed_idx    = SW'(i);
                fixed_valid  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_onehot = fixed_gnt;
        grant_idx    = fixed_idx;
        grant_valid  = fixed_valid;
        if (mode == MODE_RR) begin
            grant_onehot = rr_gnt;
            grant_idx    = rr_gnt_idx;
            grant_valid  = rr_gnt_valid;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register refills when empty or draining this cycle.
    assign load_en  = !out_valid || out_ready;
    assign take     = grant_valid && load_en && !rst;
    assign in_ready = take ? grant_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= SW'(N - 1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_idx;
            if (mode == MODE_RR) begin
                rr_ptr <= grant_idx;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
